// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage for the EX-stage ALU: decodes MIPS opcode/funct into the
// 3-bit ALU control code, selects/extends operands and registers them with stall/flush.
module id_ex_alu_issue #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         id_valid,
  input  logic         stall,
  input  logic         flush,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt,
  input  logic [15:0]  imm16,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  output logic         ex_valid,
  output logic [W-1:0] ex_A,
  output logic [W-1:0] ex_B,
  output logic [2:0]   ex_alu_ctr,
  output logic         ex_ovf_chk,
  output logic         ex_illegal
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [W-1:0] sext_s;
  logic [W-1:0] zext_s;
  logic [W-1:0] shamt_s;
  logic [W-1:0] lui_s;

  assign sext_s  = {{(W-16){imm16[15]}}, imm16};
  assign zext_s  = {{(W-16){1'b0}}, imm16};
  assign shamt_s = {{(W-5){1'b0}}, shamt};
  assign lui_s   = {imm16, {(W-16){1'b0}}};

  logic [W-1:0] dec_a_s;
  logic [W-1:0] dec_b_s;
  logic [2:0]   dec_ctr_s;
  logic         dec_chk_s;
  logic         dec_ill_s;

  // Combinational decode; unknown encodings fall through to the illegal defaults.
  always_comb begin
    dec_a_s   = {W{1'b0}};
    dec_b_s   = {W{1'b0}};
    dec_ctr_s = ALU_ADD;
    dec_chk_s = 1'b0;
    dec_ill_s = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_ctr_s = ALU_ADD; dec_a_s = rs_data; dec_b_s = rt_data; dec_chk_s = 1'b1; end
          6'h21: begin dec_ctr_s = ALU_ADD; dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h22: begin dec_ctr_s = ALU_SUB; dec_a_s = rs_data; dec_b_s = rt_data; dec_chk_s = 1'b1; end
          6'h23: begin dec_ctr_s = ALU_SUB; dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h24: begin dec_ctr_s = ALU_AND; dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h25: begin dec_ctr_s = ALU_OR;  dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h26: begin dec_ctr_s = ALU_XOR; dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h2A: begin dec_ctr_s = ALU_SLT; dec_a_s = rs_data; dec_b_s = rt_data; end
          6'h00: begin dec_ctr_s = ALU_SLL; dec_a_s = rt_data; dec_b_s = shamt_s; end
          6'h02: begin dec_ctr_s = ALU_SRL; dec_a_s = rt_data; dec_b_s = shamt_s; end
          6'h04: begin dec_ctr_s = ALU_SLL; dec_a_s = rt_data; dec_b_s = rs_data; end
          6'h06: begin dec_ctr_s = ALU_SRL; dec_a_s = rt_data; dec_b_s = rs_data; end
          default: dec_ill_s = 1'b1;
        endcase
      end
      6'h08: begin dec_ctr_s = ALU_ADD; dec_a_s = rs_data; dec_b_s = sext_s; dec_chk_s = 1'b1; end
      6'h09: begin dec_ctr_s = ALU_ADD; dec_a_s = rs_data; dec_b_s = sext_s; end
      6'h0A: begin dec_ctr_s = ALU_SLT; dec_a_s = rs_data; dec_b_s = sext_s; end
      6'h0C: begin dec_ctr_s = ALU_AND; dec_a_s = rs_data; dec_b_s = zext_s; end
      6'h0D: begin dec_ctr_s = ALU_OR;  dec_a_s = rs_data; dec_b_s = zext_s; end
      6'h0E: begin dec_ctr_s = ALU_XOR; dec_a_s = rs_data; dec_b_s = zext_s; end
      6'h0F: begin dec_ctr_s = ALU_OR;  dec_a_s = lui_s;   dec_b_s = {W{1'b0}}; end
      6'h23, 6'h2B: begin dec_ctr_s = ALU_ADD; dec_a_s = rs_data; dec_b_s = sext_s; end
      6'h04, 6'h05: begin dec_ctr_s = ALU_SUB; dec_a_s = rs_data; dec_b_s = rt_data; end
      default: dec_ill_s = 1'b1;
    endcase
  end

  logic         valid_q, valid_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [2:0]   ctr_q, ctr_d;
  logic         chk_q, chk_d;
  logic         ill_q, ill_d;

  // Next-state priority: flush bubble, stall hold, idle bubble, then load.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    ctr_d   = ctr_q;
    chk_d   = chk_q;
    ill_d   = ill_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d = 1'b0;
      a_d     = {W{1'b0}};
      b_d     = {W{1'b0}};
      ctr_d   = 3'b000;
      chk_d   = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      a_d     = dec_a_s;
      b_d     = dec_b_s;
      ctr_d   = dec_ctr_s;
      chk_d   = dec_chk_s;
      ill_d   = dec_ill_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      ctr_q   <= 3'b000;
      chk_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_q   <= ctr_d;
      chk_q   <= chk_d;
      ill_q   <= ill_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_A       = a_q;
  assign ex_B       = b_q;
  assign ex_alu_ctr = ctr_q;
  assign ex_ovf_chk = chk_q;
  assign ex_illegal = ill_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: directed instructions push expected
// ID/EX contents; a monitor pops and compares one entry after each rising edge.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data;
  logic        ex_valid, ex_ovf_chk, ex_illegal;
  logic [31:0] ex_A, ex_B;
  logic [2:0]  ex_alu_ctr;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_alu_ctr(ex_alu_ctr),
    .ex_ovf_chk(ex_ovf_chk), .ex_illegal(ex_illegal)
  );

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic        k;
    logic        il;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check_out(input exp_t e);
    n_total++;
    if (ex_valid === e.v && ex_A === e.a && ex_B === e.b && ex_alu_ctr === e.c &&
        ex_ovf_chk === e.k && ex_illegal === e.il) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got v=%b A=%h B=%h ctr=%b chk=%b ill=%b, want v=%b A=%h B=%h ctr=%b chk=%b ill=%b",
               e.nm, ex_valid, ex_A, ex_B, ex_alu_ctr, ex_ovf_chk, ex_illegal,
               e.v, e.a, e.b, e.c, e.k, e.il);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 2 time units after it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) check_out(q.pop_front());
    end
  end

  task automatic issue(input string nm, input logic iv, input logic st, input logic fl,
                       input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                       input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [2:0] ec, input logic ek, input logic eil);
    exp_t e;
    @(negedge clk);
    id_valid = iv; stall = st; flush = fl;
    opcode = op; funct = fn; shamt = sh; imm16 = im; rs_data = rs; rt_data = rt;
    e.nm = nm; e.v = ev; e.a = ea; e.b = eb; e.c = ec; e.k = ek; e.il = eil;
    q.push_back(e);
    last = e;
  endtask

  // Stall cycle with a different instruction on the inputs; contents must not move.
  task automatic hold(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    @(negedge clk);
    id_valid = 1'b1; stall = 1'b1; flush = 1'b0;
    opcode = op; funct = fn; rs_data = rs; rt_data = rt; imm16 = 16'h5555;
    e = last;
    e.nm = nm;
    q.push_back(e);
  endtask

  exp_t zero_e;

  initial begin
    zero_e.nm = "reset"; zero_e.v = 1'b0; zero_e.a = 32'h0; zero_e.b = 32'h0;
    zero_e.c = 3'b000; zero_e.k = 1'b0; zero_e.il = 1'b0;
    rst_n = 1'b0;
    id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    opcode = 6'h00; funct = 6'h20; shamt = 5'($urandom);
    imm16 = 16'($urandom); rs_data = $urandom; rt_data = $urandom;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
      rs_data = $urandom; rt_data = $urandom;
      zero_e.nm = "reset_hold";
      check_out(zero_e);
    end

    @(negedge clk);
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    #1;
    zero_e.nm = "reset_release";
    check_out(zero_e);
    zero_e.nm = "post_reset_bubble";
    q.push_back(zero_e);

    //     name       iv   st   fl   op     fn     sh     imm       rs            rt            v    A             B             ctr     chk  ill
    issue("add",    1'b1,1'b0,1'b0,6'h00,6'h20,5'd0, 16'h0000,32'h7FFFFFFF,32'h00000001, 1'b1,32'h7FFFFFFF,32'h00000001,3'b010,1'b1,1'b0);
    issue("addu",   1'b1,1'b0,1'b0,6'h00,6'h21,5'd0, 16'h0000,32'h7FFFFFFF,32'h00000001, 1'b1,32'h7FFFFFFF,32'h00000001,3'b010,1'b0,1'b0);
    issue("addi",   1'b1,1'b0,1'b0,6'h08,6'h3F,5'd0, 16'hFFFC,32'h00000010,32'hDEADBEEF, 1'b1,32'h00000010,32'hFFFFFFFC,3'b010,1'b1,1'b0);
    issue("ori",    1'b1,1'b0,1'b0,6'h0D,6'h00,5'd0, 16'hFFFC,32'h00000010,32'hDEADBEEF, 1'b1,32'h00000010,32'h0000FFFC,3'b001,1'b0,1'b0);
    issue("lui",    1'b1,1'b0,1'b0,6'h0F,6'h00,5'd0, 16'h1234,32'hAAAAAAAA,32'hBBBBBBBB, 1'b1,32'h12340000,32'h00000000,3'b001,1'b0,1'b0);
    issue("sll",    1'b1,1'b0,1'b0,6'h00,6'h00,5'd4, 16'h0000,32'h00000005,32'h0000000F, 1'b1,32'h0000000F,32'h00000004,3'b100,1'b0,1'b0);
    issue("srlv",   1'b1,1'b0,1'b0,6'h00,6'h06,5'd9, 16'h0000,32'h00000003,32'h80000000, 1'b1,32'h80000000,32'h00000003,3'b101,1'b0,1'b0);
    issue("srl",    1'b1,1'b0,1'b0,6'h00,6'h02,5'd31,16'h0000,32'h00000007,32'hFFFFFFFF, 1'b1,32'hFFFFFFFF,32'h0000001F,3'b101,1'b0,1'b0);
    issue("sllv",   1'b1,1'b0,1'b0,6'h00,6'h04,5'd2, 16'h0000,32'h00000011,32'h00000001, 1'b1,32'h00000001,32'h00000011,3'b100,1'b0,1'b0);
    issue("slti",   1'b1,1'b0,1'b0,6'h0A,6'h00,5'd0, 16'h8000,32'h00000005,32'h0,         1'b1,32'h00000005,32'hFFFF8000,3'b111,1'b0,1'b0);
    issue("andi",   1'b1,1'b0,1'b0,6'h0C,6'h00,5'd0, 16'h8000,32'h00000005,32'h0,         1'b1,32'h00000005,32'h00008000,3'b000,1'b0,1'b0);
    issue("xori",   1'b1,1'b0,1'b0,6'h0E,6'h00,5'd0, 16'hF00F,32'h12345678,32'h0,         1'b1,32'h12345678,32'h0000F00F,3'b011,1'b0,1'b0);
    issue("addiu",  1'b1,1'b0,1'b0,6'h09,6'h00,5'd0, 16'h8001,32'h00000001,32'h0,         1'b1,32'h00000001,32'hFFFF8001,3'b010,1'b0,1'b0);
    issue("lw",     1'b1,1'b0,1'b0,6'h23,6'h00,5'd0, 16'hFFF8,32'h00001000,32'h0,         1'b1,32'h00001000,32'hFFFFFFF8,3'b010,1'b0,1'b0);
    issue("sw",     1'b1,1'b0,1'b0,6'h2B,6'h00,5'd0, 16'h0004,32'h00002000,32'h99,        1'b1,32'h00002000,32'h00000004,3'b010,1'b0,1'b0);
    issue("and",    1'b1,1'b0,1'b0,6'h00,6'h24,5'd0, 16'h0000,32'hF0F0F0F0,32'h0FF00FF0, 1'b1,32'hF0F0F0F0,32'h0FF00FF0,3'b000,1'b0,1'b0);
    issue("or",     1'b1,1'b0,1'b0,6'h00,6'h25,5'd0, 16'h0000,32'h00000001,32'h00000002, 1'b1,32'h00000001,32'h00000002,3'b001,1'b0,1'b0);
    issue("xor",    1'b1,1'b0,1'b0,6'h00,6'h26,5'd0, 16'h0000,32'h00000003,32'h00000004, 1'b1,32'h00000003,32'h00000004,3'b011,1'b0,1'b0);
    issue("slt",    1'b1,1'b0,1'b0,6'h00,6'h2A,5'd0, 16'h0000,32'hFFFFFFFF,32'h00000001, 1'b1,32'hFFFFFFFF,32'h00000001,3'b111,1'b0,1'b0);
    issue("subu",   1'b1,1'b0,1'b0,6'h00,6'h23,5'd0, 16'h0000,32'h00000000,32'h00000001, 1'b1,32'h00000000,32'h00000001,3'b110,1'b0,1'b0);
    issue("sub",    1'b1,1'b0,1'b0,6'h00,6'h22,5'd0, 16'h0000,32'h80000000,32'h00000001, 1'b1,32'h80000000,32'h00000001,3'b110,1'b1,1'b0);
    hold("stall1", 6'h00, 6'h26, 32'h11111111, 32'h22222222);
    hold("stall2", 6'h08, 6'h00, 32'h33333333, 32'h44444444);
    hold("stall3", 6'h3F, 6'h00, 32'h55555555, 32'h66666666);
    issue("stall_flush",1'b1,1'b1,1'b1,6'h00,6'h20,5'd0,16'h0000,32'h7FFFFFFF,32'h00000001,1'b0,32'h0,32'h0,3'b000,1'b0,1'b0);
    hold("stall_bubble", 6'h00, 6'h20, 32'h1, 32'h2);
    issue("beq",    1'b1,1'b0,1'b0,6'h04,6'h00,5'd0, 16'h0010,32'h00000001,32'h00000002, 1'b1,32'h00000001,32'h00000002,3'b110,1'b0,1'b0);
    issue("bne",    1'b1,1'b0,1'b0,6'h05,6'h00,5'd0, 16'h0010,32'h00000003,32'h00000004, 1'b1,32'h00000003,32'h00000004,3'b110,1'b0,1'b0);
    issue("add2",   1'b1,1'b0,1'b0,6'h00,6'h20,5'd0, 16'h0000,32'h00000005,32'h00000006, 1'b1,32'h00000005,32'h00000006,3'b010,1'b1,1'b0);
    issue("flush",  1'b1,1'b0,1'b1,6'h00,6'h20,5'd0, 16'h0000,32'h00000005,32'h00000006, 1'b0,32'h0,32'h0,3'b000,1'b0,1'b0);
    issue("ill_op", 1'b1,1'b0,1'b0,6'h3F,6'h20,5'd0, 16'hFFFF,32'h12345678,32'h9ABCDEF0, 1'b1,32'h0,32'h0,3'b010,1'b0,1'b1);
    issue("ill_fn", 1'b1,1'b0,1'b0,6'h00,6'h01,5'd3, 16'h0000,32'h12345678,32'h9ABCDEF0, 1'b1,32'h0,32'h0,3'b010,1'b0,1'b1);
    issue("idle",   1'b0,1'b0,1'b0,6'h00,6'h20,5'd0, 16'h0000,32'h7FFFFFFF,32'h00000001, 1'b0,32'h0,32'h0,3'b000,1'b0,1'b0);
    issue("idle_ill",1'b0,1'b0,1'b0,6'h3F,6'h00,5'd0,16'h0000,32'hFFFFFFFF,32'hFFFFFFFF, 1'b0,32'h0,32'h0,3'b000,1'b0,1'b0);
    issue("add3",   1'b1,1'b0,1'b0,6'h00,6'h20,5'd0, 16'h0000,32'hCAFEF00D,32'h00000010, 1'b1,32'hCAFEF00D,32'h00000010,3'b010,1'b1,1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d entries pending, want 0", q.size());
    end

    @(negedge clk);
    id_valid = 1'b1; stall = 1'b1; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    zero_e.nm = "reset_mid_stall";
    check_out(zero_e);
    @(negedge clk);
    stall = 1'b0; flush = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    flush = 1'b0; opcode = 6'h00; funct = 6'h20;
    #2;
    rst_n = 1'b0;
    #1;
    zero_e.nm = "reset_mid_load";
    check_out(zero_e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage that drives the EX-stage ALU. It is the producer side of the ALU interface.
- Decodes the MIPS opcode/funct into the 3-bit ALU control code and selects and extends the operands.
- Registers A, B and ALU_Ctr into the ID/EX register with stall and flush. It also emits an overflow-check qualifier, so EX raises an overflow exception only for trapping arithmetic (add/sub/addi).

Parameters:
- W, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- stall  input  1  hazard unit: hold ID/EX contents
- flush  input  1  branch/exception: insert bubble
- opcode  input  6  instr[31:26]
- funct  input  6  instr[5:0]
- shamt  input  5  instr[10:6]
- imm16  input  16  instr[15:0]
- rs_data  input  32  forwarded rs value
- rt_data  input  32  forwarded rt value
- ex_valid  output  1  ID/EX holds a real instruction
- ex_A  output  32  ALU operand A
- ex_B  output  32  ALU operand B
- ex_alu_ctr  output  3  ALU control code
- ex_ovf_chk  output  1  EX must trap when the ALU overflow output is 1
- ex_illegal  output  1  reserved-instruction flag

Behaviour:
- ALU_Ctr encoding (fixed): 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLL (A shifted left by B[4:0]), 101 SRL (A shifted right logically by B[4:0]), 110 SUB (A-B), 111 SLT (signed A<B, result 0/1).
- Sign-extend = {{16{imm16[15]}}, imm16}; zero-extend = {16'b0, imm16}.
- R-type decode (opcode 000000), listed as funct: ctr, A, B, chk:
  - 20 add: 010, rs, rt, 1
  - 21 addu: 010, rs, rt, 0
  - 22 sub: 110, rs, rt, 1
  - 23 subu: 110, rs, rt, 0
  - 24 and: 000, rs, rt, 0
  - 25 or: 001, rs, rt, 0
  - 26 xor: 011, rs, rt, 0
  - 2A slt: 111, rs, rt, 0
  - 00 sll: 100, A=rt, B={27'b0,shamt}, 0
  - 02 srl: 101, A=rt, B={27'b0,shamt}, 0
  - 04 sllv: 100, A=rt, B=rs, 0
  - 06 srlv: 101, A=rt, B=rs, 0
- I-type decode, listed as opcode: ctr, A, B, chk:
  - 08 addi: 010, rs, sext, 1
  - 09 addiu: 010, rs, sext, 0
  - 0A slti: 111, rs, sext, 0
  - 0C andi: 000, rs, zext, 0
  - 0D ori: 001, rs, zext, 0
  - 0E xori: 011, rs, zext, 0
  - 0F lui: 001, A={imm16,16'b0}, B=0, 0
  - 23 lw / 2B sw: 010, rs, sext, 0
  - 04 beq / 05 bne: 110, rs, rt, 0
- Any other opcode/funct: illegal=1, ctr=010, A=0, B=0, chk=0.
- Reset (rst_n low, asynchronous): all outputs 0, i.e. ex_valid=0 and ex_alu_ctr=000. Outputs stay 0 until the first rising clk after rst_n deasserts.
- Latency: decode is combinational. Outputs update on the rising clk edge, so there is 1 cycle from ID to EX.
- Register update priority per rising edge:
  1. flush=1: load a bubble. A bubble sets ex_valid=0 and zeroes all other outputs (ctr=000, chk=0, illegal=0). flush overrides stall.
  2. stall=1: hold every output unchanged, including ex_valid.
  3. id_valid=0: load a bubble.
  4. Otherwise: load the decoded fields with ex_valid=1.
- A bubble never asserts ex_ovf_chk or ex_illegal, so a flushed add cannot trap.
- Decode depends only on opcode/funct. When id_valid=0, rs_data/rt_data are don't-care and have no effect.
- rst_n asserted mid-stall or mid-flush: the asynchronous reset wins immediately.

Test Plan:
- Reset: hold rst_n=0 with random inputs and clk running -> all outputs 0. Release rst_n -> outputs still 0 until the next edge.
- add: rs=7FFFFFFF, rt=1, id_valid=1 -> next cycle ex_A=7FFFFFFF, ex_B=00000001, ctr=010, chk=1, valid=1. Repeat as addu -> chk=0.
- Immediate extension: addi imm16=FFFC with rs=10 -> B=FFFFFFFC, ctr=010. ori imm16=FFFC -> B=0000FFFC, ctr=001. lui imm16=1234 -> A=12340000, B=0, ctr=001.
- Shifts: sll shamt=4, rt=0000000F -> A=0000000F, B=00000004, ctr=100. srlv rs=3, rt=80000000 -> A=80000000, B=00000003, ctr=101.
- Stall/flush: load sub (ctr=110, chk=1), then stall=1 for 3 cycles with new instructions on the inputs -> outputs frozen. Assert stall=1 and flush=1 together -> bubble (valid=0, chk=0). Then beq -> ctr=110, chk=0.
- Illegal: opcode=3F -> valid=1, illegal=1, A=B=0, ctr=010. id_valid=0 -> bubble with illegal=0.
